// File: rtl/div_sweep_ctrl.sv
// div_sweep_ctrl: steps the ADC-path clock divider through a table of divide
// ratios. Each step loads a ratio, holds the divider in reset for one cycle,
// lets it settle, then issues cfg_len sample strobes at the divided rate.
// Optional build macro: DIV_SWEEP_LOOP_EN adds loop_en to repeat the sweep.
module div_sweep_ctrl #(
  parameter int unsigned TABLE_DEPTH = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter logic [31:0] DIV_MIN     = 32'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_div,
  input  logic [15:0]      cfg_len,
  input  logic [IDX_W:0]   cfg_nsteps,
  input  logic             start,
  input  logic             abort,
  input  logic             cap_ready,
`ifdef DIV_SWEEP_LOOP_EN
  input  logic             loop_en,
`endif
  output logic [31:0]      div_num,
  output logic             div_rst_n,
  output logic             samp_en,
  output logic [IDX_W-1:0] step_idx,
  output logic [15:0]      samp_idx,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_NEXT, S_DONE
  } state_t;

  localparam logic [IDX_W:0] DEPTH_N  = (IDX_W+1)'(TABLE_DEPTH);
  localparam logic [31:0]    SETTLE_L = 32'(SETTLE_CYC - 1);

  state_t          state, state_nx;
  logic [31:0]     tbl [TABLE_DEPTH];
  logic [31:0]     cnt;
  logic [15:0]     len;
  logic [IDX_W:0]  nsteps;
  logic            start_ok, last_step, strobe, run_end, settle_end, loop_again;

`ifdef DIV_SWEEP_LOOP_EN
  assign loop_again = loop_en;
`else
  assign loop_again = 1'b0;
`endif

  assign start_ok   = start & ~abort & (state == S_IDLE);
  assign last_step  = ({1'b0, step_idx} == nsteps - (IDX_W+1)'(1));
  assign settle_end = (state == S_SETTLE) && (cnt == SETTLE_L);
  assign strobe     = (state == S_RUN) && (len != 16'd0) && (cnt == div_num - 32'd1);
  assign run_end    = (state == S_RUN) &&
                      ((len == 16'd0) || (strobe && (samp_idx == len - 16'd1)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and state-derived outputs; abort overrides everything.
  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    div_rst_n = (state != S_IDLE) && (state != S_LOAD);
    samp_en   = strobe & ~abort;
    case (state)
      S_IDLE:   if (start_ok && (cfg_nsteps != '0)) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_SETTLE;
      S_SETTLE: if (settle_end) state_nx = S_RUN;
      S_RUN:    if (run_end) state_nx = S_NEXT;
      S_NEXT:   state_nx = (!last_step || loop_again) ? S_LOAD : S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Ratio table: host writes only land while idle; contents are not reset.
  always_ff @(posedge clk) begin
    if (cfg_we && (state == S_IDLE)) tbl[cfg_addr] <= cfg_div;
  end

  // Sweep datapath: ratio, shared settle/phase counter, indices, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_num  <= DIV_MIN;
      step_idx <= '0;
      samp_idx <= '0;
      done     <= 1'b0;
      err_ovf  <= 1'b0;
      cnt      <= '0;
      len      <= '0;
      nsteps   <= '0;
    end else begin
      done <= 1'b0;
      if (samp_en && !cap_ready) err_ovf <= 1'b1;
      if (start_ok) begin
        err_ovf  <= 1'b0;
        step_idx <= '0;
        len      <= cfg_len;
        nsteps   <= (cfg_nsteps > DEPTH_N) ? DEPTH_N : cfg_nsteps;
        if (cfg_nsteps == '0) done <= 1'b1;
      end
      // Skipping updates under abort keeps done from pulsing on an aborted NEXT.
      if (!abort) begin
        case (state)
          S_LOAD: begin
            div_num <= (tbl[step_idx] < DIV_MIN) ? DIV_MIN : tbl[step_idx];
            cnt     <= '0;
          end
          S_SETTLE: begin
            cnt <= settle_end ? '0 : cnt + 32'd1;
            if (settle_end) samp_idx <= '0;
          end
          S_RUN: begin
            cnt <= strobe ? '0 : cnt + 32'd1;
            if (strobe) samp_idx <= samp_idx + 16'd1;
          end
          S_NEXT: begin
            if (!last_step) begin
              step_idx <= step_idx + IDX_W'(1);
            end else begin
              done <= 1'b1;
              if (loop_again) step_idx <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
